// File: rtl/mem_access_controller_pkg.sv
// Shared types and helpers for the memory access sequencer.
// Holds state encoding, access size codes, timeout default and alignment check.
package mem_access_pkg;

    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_REL  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Size 3 has no meaning and is never aligned.
    function automatic logic is_aligned(
        input logic [1:0] size,
        input logic [8:0] addr
    );
        logic ok;
        ok = 1'b0;
        unique case (1'b1)
            (size == SZ_BYTE): ok = 1'b1;
            (size == SZ_HALF): ok = ~addr[0];
            (size == SZ_WORD): ok = (addr[1:0] == 2'b00);
            default:           ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_controller_if.sv
// Control-unit and RAM-side signal bundle of the memory access sequencer.
// slave: the sequencer; master: control unit plus RAM driving the other side.
interface mem_access_controller_if;

    logic        req;
    logic        rw;
    logic [1:0]  size;
    logic        sgn;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;

    logic        ram_enable;
    logic        ram_rw;
    logic        ram_sig;
    logic [1:0]  ram_len;
    logic [8:0]  ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
    logic        ram_mfc;

    modport slave (
        input  req, rw, size, sgn, addr, wdata,
        input  ram_dout, ram_mfc,
        output busy, done, err, rdata,
        output ram_enable, ram_rw, ram_sig,
        output ram_len, ram_addr, ram_din
    );

    modport master (
        output req, rw, size, sgn, addr, wdata,
        output ram_dout, ram_mfc,
        input  busy, done, err, rdata,
        input  ram_enable, ram_rw, ram_sig,
        input  ram_len, ram_addr, ram_din
    );

endinterface

// File: rtl/mem_access_controller_timer.sv
// Handshake phase timer shared by the WAIT and REL phases.
// Ports: clk, reset, clr, inc in; expired out (next inc reaches TIMEOUT).
module mem_access_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Looking one step ahead makes the abort land on the
    // TIMEOUT-th edge without the awaited mfc level.
    assign expired = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_controller.sv
// Load/store sequencer between the control unit and the 512-byte RAM.
// Ports: clk, reset, bus (slave): request in, status/rdata out, RAM drive.
module mem_access_controller
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    mem_access_controller_if.slave  bus
);

    state_t state;
    state_t state_nx;

    logic legal;
    logic accept;
    logic take_rd;
    logic t_clr;
    logic t_inc;
    logic t_exp;

    mem_access_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (t_clr),
        .inc     (t_inc),
        .expired (t_exp)
    );

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        take_rd  = 1'b0;
        t_clr    = 1'b0;
        t_inc    = 1'b0;
        legal    = is_aligned(bus.size, bus.addr);
        unique case (state)
            ST_IDLE: begin
                t_clr = 1'b1;
                if (bus.req) begin
                    if (legal) begin
                        accept   = 1'b1;
                        state_nx = ST_WAIT;
                    end else begin
                        state_nx = ST_ERR;
                    end
                end
            end
            ST_WAIT: begin
                if (bus.ram_mfc) begin
                    take_rd  = bus.ram_rw;
                    t_clr    = 1'b1;
                    state_nx = ST_REL;
                end else begin
                    t_inc = 1'b1;
                    if (t_exp) begin
                        state_nx = ST_ERR;
                    end
                end
            end
            ST_REL: begin
                if (!bus.ram_mfc) begin
                    t_clr    = 1'b1;
                    state_nx = ST_DONE;
                end else begin
                    t_inc = 1'b1;
                    if (t_exp) begin
                        state_nx = ST_ERR;
                    end
                end
            end
            ST_DONE, ST_ERR: begin
                t_clr    = 1'b1;
                state_nx = ST_IDLE;
            end
            default: begin
                t_clr    = 1'b1;
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they
    // line up exactly with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
            bus.ram_enable <= 1'b0;
        end else begin
            state          <= state_nx;
            bus.busy       <= (state_nx != ST_IDLE);
            bus.done       <= (state_nx == ST_DONE) ||
                              (state_nx == ST_ERR);
            bus.err        <= (state_nx == ST_ERR);
            bus.ram_enable <= (state_nx == ST_WAIT);
        end
    end

    // RAM-side request registers hold until the next acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.ram_rw   <= 1'b0;
            bus.ram_sig  <= 1'b0;
            bus.ram_len  <= 2'd0;
            bus.ram_addr <= 9'd0;
            bus.ram_din  <= 32'd0;
        end else if (accept) begin
            bus.ram_rw   <= bus.rw;
            bus.ram_sig  <= bus.sgn;
            bus.ram_len  <= bus.size;
            bus.ram_addr <= bus.addr;
            bus.ram_din  <= bus.wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rdata <= 32'd0;
        end else if (take_rd) begin
            bus.rdata <= bus.ram_dout;
        end
    end

endmodule

// File: tb/tb_mem_access_controller.sv
// Randomized self-checking bench for mem_access_controller.
// Includes a behavioural RAM and a transaction-level reference memory.
module tb_mem_access_controller;
    import mem_access_pkg::*;

    localparam int M_RAND   = 0;
    localparam int M_FAST   = 1;
    localparam int M_STUCK0 = 2;
    localparam int M_STUCK1 = 3;

    logic clk = 1'b0;
    logic reset;
    int   mode = M_RAND;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   lat;

    logic [7:0]  ram_mem [512];
    logic [7:0]  ref_mem [512];
    logic [31:0] exp_rdata = 32'd0;

    always #5 clk = ~clk;

    mem_access_controller_if bus ();

    mem_access_controller #(
        .TIMEOUT (15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h",
                     tag, got, exp);
        end
    endtask

    // Behavioural RAM: little-endian, sign fill on loads.
    task automatic ram_access();
        logic [8:0]  a;
        logic [31:0] v;
        int          nb;
        a  = bus.ram_addr;
        nb = (bus.ram_len == 2'd2) ? 4 : (bus.ram_len == 2'd1) ? 2 : 1;
        v  = 32'd0;
        if (!bus.ram_rw) begin
            for (int i = 0; i < nb; i++)
                ram_mem[a + 9'(i)] = bus.ram_din[8*i +: 8];
        end else begin
            for (int i = 0; i < nb; i++)
                v[8*i +: 8] = ram_mem[a + 9'(i)];
            if (bus.ram_sig && v[8*nb-1])
                for (int i = nb; i < 4; i++)
                    v[8*i +: 8] = 8'hFF;
            bus.ram_dout = v;
        end
    endtask

    initial begin
        int dly;
        dly = -1;
        bus.ram_mfc  = 1'b0;
        bus.ram_dout = 32'd0;
        forever begin
            @(negedge clk);
            if (mode == M_STUCK0) begin
                bus.ram_mfc = 1'b0;
                dly = -1;
            end else if (mode == M_STUCK1) begin
                bus.ram_mfc = 1'b1;
                dly = -1;
            end else if (bus.ram_enable != bus.ram_mfc) begin
                if (dly < 0)
                    dly = (mode == M_FAST) ? 0 : int'($urandom_range(0, 3));
                if (dly == 0) begin
                    if (bus.ram_enable)
                        ram_access();
                    bus.ram_mfc = bus.ram_enable;
                    dly = -1;
                end else begin
                    dly--;
                end
            end
        end
    end

    function automatic logic [31:0] ref_load(input logic [8:0] a,
                                             input logic [1:0] sz,
                                             input logic sg);
        longint v;
        int     nb;
        v  = 0;
        nb = 1 << sz;
        for (int i = 0; i < nb; i++)
            v = v + (longint'(ref_mem[a + 9'(i)]) << (8 * i));
        if (sg && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
            v = v - (longint'(1) << (8 * nb));
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [8:0] a,
                             input logic [1:0] sz,
                             input logic [31:0] wd);
        for (int i = 0; i < (1 << sz); i++)
            ref_mem[a + 9'(i)] = wd[8*i +: 8];
    endtask

    task automatic run_req(input logic rw, input logic [1:0] sz,
                           input logic sg, input logic [8:0] a,
                           input logic [31:0] wd, output int n);
        bit legal;
        bit exp_err;
        legal   = (sz != 2'd3) && ((int'(a) % (1 << sz)) == 0);
        exp_err = !legal || mode == M_STUCK0 || mode == M_STUCK1;
        @(negedge clk);
        bus.req   = 1'b1;
        bus.rw    = rw;
        bus.size  = sz;
        bus.sgn   = sg;
        bus.addr  = a;
        bus.wdata = wd;
        @(posedge clk);
        #1;
        n = 0;
        check("busy_acc", bus.busy, 1);
        check("en_acc", bus.ram_enable, legal);
        if (legal) begin
            check("ram_addr", bus.ram_addr, a);
            check("ram_len", bus.ram_len, sz);
            check("ram_rw", bus.ram_rw, rw);
            check("ram_sig", bus.ram_sig, sg);
            check("ram_din", bus.ram_din, wd);
        end
        // req stays high while busy; its fields change and must be ignored
        bus.addr  = 9'($urandom);
        bus.wdata = $urandom;
        bus.size  = 2'($urandom);
        bus.rw    = 1'($urandom);
        bus.sgn   = 1'($urandom);
        while (!bus.done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_seen", bus.done, 1);
        check("err", bus.err, exp_err);
        bus.req = 1'b0;
        if (!exp_err) begin
            if (rw)
                exp_rdata = ref_load(a, sz, sg);
            else
                ref_store(a, sz, wd);
        end
        check("rdata", bus.rdata, exp_rdata);
        check("en_done", bus.ram_enable, 0);
        if (legal)
            check("addr_hold", bus.ram_addr, a);
        @(posedge clk);
        #1;
        check("done_once", bus.done, 0);
        check("busy_idle", bus.busy, 0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            ram_mem[i] = 8'($urandom);
            ref_mem[i] = ram_mem[i];
        end
        reset     = 1'b1;
        bus.req   = 1'b0;
        bus.rw    = 1'b0;
        bus.size  = 2'd0;
        bus.sgn   = 1'b0;
        bus.addr  = 9'd0;
        bus.wdata = 32'd0;
        #12;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_en", bus.ram_enable, 0);
        check("rst_rw", bus.ram_rw, 0);
        check("rst_sig", bus.ram_sig, 0);
        check("rst_len", bus.ram_len, 0);
        check("rst_addr", bus.ram_addr, 0);
        check("rst_din", bus.ram_din, 0);
        @(negedge clk);
        reset = 1'b0;

        run_req(1'b0, SZ_BYTE, 1'b0, 9'h000, 32'h0000_00FF, lat);
        run_req(1'b1, SZ_BYTE, 1'b1, 9'h000, 32'h0, lat);
        check("byte_ld", bus.rdata, 32'hFFFF_FFFF);
        run_req(1'b0, SZ_HALF, 1'b0, 9'h002, 32'h0000_FFFF, lat);
        run_req(1'b1, SZ_HALF, 1'b0, 9'h002, 32'h0, lat);
        check("half_ld", bus.rdata, 32'h0000_FFFF);
        run_req(1'b0, SZ_WORD, 1'b0, 9'h008, 32'h0010_0000, lat);
        mode = M_FAST;
        run_req(1'b1, SZ_WORD, 1'b0, 9'h008, 32'h0, lat);
        check("word_ld", bus.rdata, 32'h0010_0000);
        check("lat_fast", lat, 2);
        mode = M_RAND;

        run_req(1'b1, SZ_WORD, 1'b0, 9'h006, 32'h0, lat);
        check("lat_mis_w", lat, 0);
        run_req(1'b0, SZ_HALF, 1'b0, 9'h003, 32'h1234_5678, lat);
        check("lat_mis_h", lat, 0);
        check("mis_rdata", bus.rdata, 32'h0010_0000);

        for (int t = 0; t < 80; t++) begin
            mode = ($urandom_range(0, 3) == 0) ? M_FAST : M_RAND;
            run_req(1'($urandom), 2'($urandom), 1'($urandom),
                    9'($urandom), $urandom, lat);
        end
        mode = M_RAND;
        run_req(1'b1, SZ_WORD, 1'b1, 9'h008, 32'h0, lat);

        mode = M_STUCK0;
        run_req(1'b1, SZ_WORD, 1'b0, 9'h010, 32'h0, lat);
        check("lat_to_wait", lat, 15);
        mode = M_STUCK1;
        repeat (2) @(negedge clk);
        run_req(1'b0, SZ_WORD, 1'b0, 9'h014, 32'hDEAD_BEEF, lat);
        check("lat_to_rel", lat, 16);
        mode = M_RAND;
        repeat (6) @(negedge clk);

        run_req(1'b1, SZ_WORD, 1'b0, 9'h008, 32'h0, lat);
        mode = M_STUCK0;
        @(negedge clk);
        bus.req  = 1'b1;
        bus.rw   = 1'b1;
        bus.size = SZ_WORD;
        bus.sgn  = 1'b0;
        bus.addr = 9'h00C;
        @(posedge clk);
        #1;
        check("rst_pre_en", bus.ram_enable, 1);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("rst_mid_en", bus.ram_enable, 0);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_rdata", bus.rdata, 0);
        check("rst_mid_addr", bus.ram_addr, 0);
        exp_rdata = 32'd0;
        bus.req   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        mode  = M_RAND;
        repeat (2) @(negedge clk);
        run_req(1'b1, SZ_HALF, 1'b1, 9'h002, 32'h0, lat);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
